// File: rtl/afifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO.
// Syncs the write pointer, tracks fill level and drives a FWFT output stage.
module afifo_rd_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int PTR_W     = ADDR_W + 1,
    parameter int DATA_W    = 8,
    parameter int AE_THRESH = 2
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [PTR_W-1:0]  wptr_gray_async,
    output logic [PTR_W-1:0]  rptr_gray,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PTR_W-1:0]  rd_count,
    output logic              empty,
    output logic              almost_empty
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0]  r_wq1;
    logic [PTR_W-1:0]  r_wq2;
    logic [PTR_W-1:0]  r_rbin;
    logic [PTR_W-1:0]  r_rptr_gray;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    state_t            r_state;

    logic [PTR_W-1:0]  w_wbin;
    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_rbin_next;
    logic              w_has;
    logic              w_ren;

    // Two-flop synchronizer for the write-domain Gray pointer
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= wptr_gray_async;
            r_wq2 <= r_wq1;
        end
    end

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            w_wbin[i] = ^(r_wq2 >> i);
        end
    end

    assign w_count = w_wbin - r_rbin;
    assign w_has   = (w_count != '0);

    // Fetch request: first word from idle, or next word as the held one leaves
    always_comb begin
        w_ren = 1'b0;
        case (r_state)
            ST_EMPTY: w_ren = w_has;
            ST_HOLD:  w_ren = rd_ready && w_has;
            default:  w_ren = 1'b0;
        endcase
        if (rrst) begin
            w_ren = 1'b0;
        end
    end

    assign w_rbin_next = r_rbin + {{(PTR_W-1){1'b0}}, w_ren};

    // Read pointer and its Gray copy advance on every issued RAM read
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= (w_rbin_next >> 1) ^ w_rbin_next;
        end
    end

    // Output FSM: EMPTY -> FETCH (capture RAM word) -> HOLD (offer to consumer)
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state    <= ST_EMPTY;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_rd_valid <= 1'b0;
                    if (w_has) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_rd_data  <= mem_rdata;
                    r_rd_valid <= 1'b1;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= w_has ? ST_FETCH : ST_EMPTY;
                    end
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= ST_EMPTY;
                end
            endcase
        end
    end

    assign rptr_gray    = r_rptr_gray;
    assign mem_ren      = w_ren;
    assign mem_raddr    = r_rbin[ADDR_W-1:0];
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign rd_count     = w_count;
    assign empty        = (w_count == '0);
    assign almost_empty = (w_count <= AE_TH);

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Self-checking bench for afifo_rd_ctrl.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_afifo_rd_ctrl;

    localparam int ADDR_W = 4;
    localparam int PTR_W  = 5;
    localparam int DATA_W = 8;

    logic              rclk = 1'b0;
    logic              rrst = 1'b1;
    logic [PTR_W-1:0]  wptr_gray_async = '0;
    logic [PTR_W-1:0]  rptr_gray;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [PTR_W-1:0]  rd_count;
    logic              empty;
    logic              almost_empty;

    logic [DATA_W-1:0] ram [16];

    int tests = 0;
    int fails = 0;

    afifo_rd_ctrl #(
        .ADDR_W(ADDR_W), .PTR_W(PTR_W), .DATA_W(DATA_W), .AE_THRESH(2)
    ) dut (
        .rclk(rclk), .rrst(rrst),
        .wptr_gray_async(wptr_gray_async), .rptr_gray(rptr_gray),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_count(rd_count), .empty(empty), .almost_empty(almost_empty)
    );

    always #5 rclk = ~rclk;

    // Registered-read RAM model
    always @(posedge rclk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    typedef struct {
        logic [PTR_W-1:0] wgray;
        int               cnt;
        logic             exp_empty;
        logic             exp_ae;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [PTR_W-1:0] gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge rclk);
        rrst = 1'b1;
        wptr_gray_async = '0;
        rd_ready = 1'b0;
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin
        int got;
        int ren_n;
        int ts [3];
        logic [DATA_W-1:0] w [$];
        logic [ADDR_W-1:0] a [$];
        logic [PTR_W-1:0] pg;
        int bad_gray;
        int bad_hold;

        for (int i = 0; i < 16; i++) ram[i] = DATA_W'(8'h30 + i);

        vecs[0] = '{5'b00000, 0,  1'b1, 1'b1};
        vecs[1] = '{5'b00001, 1,  1'b0, 1'b1};
        vecs[2] = '{5'b00011, 2,  1'b0, 1'b1};
        vecs[3] = '{5'b00010, 3,  1'b0, 1'b0};
        vecs[4] = '{5'b00110, 4,  1'b0, 1'b0};
        vecs[5] = '{5'b11000, 16, 1'b0, 1'b0};
        vecs[6] = '{5'b01000, 15, 1'b0, 1'b0};
        vecs[7] = '{5'b00100, 7,  1'b0, 1'b0};

        // Reset values at time zero
        #1;
        chk("rst_count", 32'(rd_count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_ren", 32'(mem_ren), 0);
        chk("rst_rptr", 32'(rptr_gray), 0);

        // Table: sync latency, Gray decode, flags, single fetch then hold
        for (int k = 0; k < 8; k++) begin
            do_reset();
            wptr_gray_async = vecs[k].wgray;
            step();
            step();
            chk($sformatf("v%0d_count", k), 32'(rd_count), 32'(vecs[k].cnt));
            chk($sformatf("v%0d_empty", k), 32'(empty), 32'(vecs[k].exp_empty));
            chk($sformatf("v%0d_ae", k), 32'(almost_empty), 32'(vecs[k].exp_ae));
            chk($sformatf("v%0d_ren", k), 32'(mem_ren), 32'(vecs[k].cnt != 0));
            chk($sformatf("v%0d_raddr", k), 32'(mem_raddr), 0);
            step();
            step();
            chk($sformatf("v%0d_valid", k), 32'(rd_valid), 32'(vecs[k].cnt != 0));
            if (vecs[k].cnt != 0) begin
                chk($sformatf("v%0d_data", k), 32'(rd_data), 32'(ram[0]));
                chk($sformatf("v%0d_cnt2", k), 32'(rd_count), 32'(vecs[k].cnt - 1));
            end
        end

        // Asynchronous reset while holding a word
        @(negedge rclk);
        rrst = 1'b1;
        #1;
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_data", 32'(rd_data), 0);
        chk("arst_count", 32'(rd_count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_ae", 32'(almost_empty), 1);
        chk("arst_ren", 32'(mem_ren), 0);
        chk("arst_rptr", 32'(rptr_gray), 0);

        // Single word timeline
        do_reset();
        wptr_gray_async = 5'b00001;
        step();
        step();
        chk("sw_count", 32'(rd_count), 1);
        chk("sw_ren", 32'(mem_ren), 1);
        chk("sw_raddr", 32'(mem_raddr), 0);
        step();
        chk("sw_rptr", 32'(rptr_gray), 32'h01);
        chk("sw_empty", 32'(empty), 1);
        chk("sw_valid0", 32'(rd_valid), 0);
        step();
        chk("sw_valid1", 32'(rd_valid), 1);
        chk("sw_data", 32'(rd_data), 32'(ram[0]));

        // Backpressure, then drain three words
        do_reset();
        ram[0] = 8'hA1;
        ram[1] = 8'hB2;
        ram[2] = 8'hC3;
        wptr_gray_async = 5'b00010;
        ren_n = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (mem_ren) ren_n++;
        end
        chk("bp_ren_n", 32'(ren_n), 1);
        chk("bp_count", 32'(rd_count), 2);
        chk("bp_ae", 32'(almost_empty), 1);
        chk("bp_valid", 32'(rd_valid), 1);
        bad_hold = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (rd_data !== 8'hA1 || !rd_valid) bad_hold++;
        end
        chk("bp_hold", 32'(bad_hold), 0);
        @(negedge rclk);
        rd_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (rd_valid) begin
                w.push_back(rd_data);
                ts[got] = c;
                got++;
            end
            @(negedge rclk);
        end
        chk("bp_got", 32'(got), 3);
        if (got == 3) begin
            chk("bp_w0", 32'(w[0]), 32'hA1);
            chk("bp_w1", 32'(w[1]), 32'hB2);
            chk("bp_w2", 32'(w[2]), 32'hC3);
            chk("bp_gap1", 32'(ts[1] - ts[0]), 2);
            chk("bp_gap2", 32'(ts[2] - ts[1]), 2);
        end
        step();
        step();
        chk("bp_end_valid", 32'(rd_valid), 0);
        chk("bp_end_empty", 32'(empty), 1);
        chk("bp_end_rptr", 32'(rptr_gray), 32'(gray(5'd3)));

        // Full RAM, drain all 16, then wrap
        do_reset();
        for (int i = 0; i < 16; i++) ram[i] = DATA_W'(8'h10 + i);
        rd_ready = 1'b1;
        wptr_gray_async = 5'b11000;
        step();
        step();
        chk("full_count", 32'(rd_count), 16);
        chk("full_empty", 32'(empty), 0);
        chk("full_ae", 32'(almost_empty), 0);
        w.delete();
        for (int c = 0; c < 60 && w.size() < 16; c++) begin
            @(negedge rclk);
            if (rd_valid) w.push_back(rd_data);
        end
        chk("full_got", 32'(w.size()), 16);
        bad_hold = 0;
        foreach (w[i]) if (w[i] !== DATA_W'(8'h10 + i)) bad_hold++;
        chk("full_order", 32'(bad_hold), 0);
        step();
        step();
        chk("full_rptr", 32'(rptr_gray), 32'(gray(5'd16)));
        chk("full_empty2", 32'(empty), 1);

        @(negedge rclk);
        for (int i = 0; i < 4; i++) ram[i] = DATA_W'(8'hE0 + i);
        wptr_gray_async = 5'b11110;
        step();
        step();
        chk("wrap_count", 32'(rd_count), 4);
        w.delete();
        a.delete();
        pg = rptr_gray;
        bad_gray = 0;
        for (int c = 0; c < 40 && w.size() < 4; c++) begin
            @(negedge rclk);
            if (mem_ren) a.push_back(mem_raddr);
            if (rd_valid) w.push_back(rd_data);
            if (rptr_gray !== pg) begin
                if ($countones(rptr_gray ^ pg) != 1) bad_gray++;
                pg = rptr_gray;
            end
        end
        chk("wrap_nren", 32'(a.size()), 4);
        chk("wrap_got", 32'(w.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < a.size()) chk($sformatf("wrap_a%0d", i), 32'(a[i]), 32'(i));
            if (i < w.size()) chk($sformatf("wrap_w%0d", i), 32'(w[i]), 32'(8'hE0 + i));
        end
        chk("wrap_gray1bit", 32'(bad_gray), 0);
        step();
        step();
        chk("wrap_rptr", 32'(rptr_gray), 32'b11110);

        // Reset during FETCH discards the word; re-read starts at 0
        do_reset();
        ram[0] = 8'h5A;
        wptr_gray_async = 5'b00011;
        step();
        step();
        chk("rf_ren", 32'(mem_ren), 1);
        step();
        rrst = 1'b1;
        #1;
        chk("rf_valid", 32'(rd_valid), 0);
        chk("rf_ren0", 32'(mem_ren), 0);
        bad_hold = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (rd_valid || mem_ren) bad_hold++;
        end
        chk("rf_quiet", 32'(bad_hold), 0);
        @(negedge rclk);
        rrst = 1'b0;
        step();
        step();
        chk("rf_count", 32'(rd_count), 2);
        chk("rf_raddr", 32'(mem_raddr), 0);
        chk("rf_ren1", 32'(mem_ren), 1);
        step();
        step();
        chk("rf_valid1", 32'(rd_valid), 1);
        chk("rf_data", 32'(rd_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
